// File: rtl/csi2_hdr_buffer.sv
// csi2_hdr_buffer: per-lane CSI-2 packet-header queue feeding one arbiter
// request port. Headers are pushed into a small FIFO; the head entry is
// presented to the arbiter, and after the grant long packets issue
// line-buffer read strobes for their payload before a one-cycle
// transfer-done pulse pops the entry.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   hdr_wr_i                push one header {SPtype, dtype, wdcnt}
//   hdr_wdcnt_i/dtype_i/SPtype_i  header fields to push
//   hdr_full_o              FIFO holds FIFO_DEPTH entries (registered)
//   hdr_ovf_o               sticky: push attempted while full
//   arb_gnt_i               grant from the arbiter (used only in REQ)
//   c2d_rd_rdy_i            downstream accepts one payload word
//   hdr_req_o               request to the arbiter
//   hdr_wdcnt_o/dtype_o/chID_o/SPtype_o  head header fields
//   hdr_rd_lbfr_en_o        line-buffer read strobe
//   hdr_xfrdone_o           one-cycle end-of-packet pulse
module csi2_hdr_buffer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LBFR_BYTES = 4,
  parameter logic [1:0]  CH_ID      = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hdr_wr_i,
  input  logic [15:0] hdr_wdcnt_i,
  input  logic [5:0]  hdr_dtype_i,
  input  logic        hdr_SPtype_i,
  output logic        hdr_full_o,
  output logic        hdr_ovf_o,
  input  logic        arb_gnt_i,
  input  logic        c2d_rd_rdy_i,
  output logic        hdr_req_o,
  output logic [15:0] hdr_wdcnt_o,
  output logic [5:0]  hdr_dtype_o,
  output logic [1:0]  hdr_chID_o,
  output logic        hdr_SPtype_o,
  output logic        hdr_rd_lbfr_en_o,
  output logic        hdr_xfrdone_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SH_W  = $clog2(LBFR_BYTES);
  localparam int unsigned RDC_W = 17;

  typedef struct packed {
    logic        sp;
    logic [5:0]  dtype;
    logic [15:0] wdcnt;
  } hdr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  hdr_t               r_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_full;
  logic               r_ovf;
  logic [RDC_W-1:0]   r_rd_cnt;
  logic [RDC_W-1:0]   w_ceil;
  logic [15:0]        r_wdcnt;
  logic [5:0]         r_dtype;
  logic               r_sp;
  logic               w_is_full;
  logic               w_push;
  logic               w_pop;
  logic               w_load_hdr;
  logic               w_load_cnt;
  logic               w_strobe;
  hdr_t               w_head;
  hdr_t               w_wr_ent;

  // Full is judged on current occupancy, so a push while full is dropped
  // even when the same cycle pops.
  assign w_is_full = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_push    = hdr_wr_i & ~w_is_full;
  assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head    = r_mem[r_rptr];
  assign w_wr_ent  = '{sp: hdr_SPtype_i, dtype: hdr_dtype_i, wdcnt: hdr_wdcnt_i};

  // Number of line-buffer reads for the held word count (ceiling divide).
  assign w_ceil = (RDC_W'(r_wdcnt) + RDC_W'(LBFR_BYTES - 1)) >> SH_W;

  // FIFO storage (no reset needed; validity tracked by r_cnt)
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wr_ent;
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CNT_W'(FIFO_DEPTH));
      if (hdr_wr_i && w_is_full) r_ovf <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load_hdr  = 1'b0;
    w_load_cnt  = 1'b0;
    w_strobe    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_load_hdr  = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (arb_gnt_i) begin
          if (r_sp || (r_wdcnt == 16'd0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_load_cnt  = 1'b1;
            w_state_nxt = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (c2d_rd_rdy_i) begin
          w_strobe = 1'b1;
          if (r_rd_cnt == RDC_W'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_pop       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Head field registers and payload read counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdcnt  <= '0;
      r_dtype  <= '0;
      r_sp     <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      if (w_load_hdr) begin
        r_wdcnt <= w_head.wdcnt;
        r_dtype <= w_head.dtype;
        r_sp    <= w_head.sp;
      end
      if (w_load_cnt)    r_rd_cnt <= w_ceil;
      else if (w_strobe) r_rd_cnt <= r_rd_cnt - RDC_W'(1);
    end
  end

  assign hdr_req_o        = (r_state == S_REQ);
  assign hdr_xfrdone_o    = (r_state == S_DONE);
  // Gated by reset so the strobe drops in the cycle reset is sampled.
  assign hdr_rd_lbfr_en_o = w_strobe & ~rst_i;
  assign hdr_full_o       = r_full;
  assign hdr_ovf_o        = r_ovf;
  assign hdr_wdcnt_o      = r_wdcnt;
  assign hdr_dtype_o      = r_dtype;
  assign hdr_SPtype_o     = r_sp;
  assign hdr_chID_o       = CH_ID;

endmodule

// File: tb/tb_csi2_hdr_buffer.sv
// Directed testbench for csi2_hdr_buffer (FIFO_DEPTH=4, LBFR_BYTES=4, CH_ID=2).
module tb_csi2_hdr_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hdr_wr_i;
  logic [15:0] hdr_wdcnt_i;
  logic [5:0]  hdr_dtype_i;
  logic        hdr_SPtype_i;
  logic        hdr_full_o;
  logic        hdr_ovf_o;
  logic        arb_gnt_i;
  logic        c2d_rd_rdy_i;
  logic        hdr_req_o;
  logic [15:0] hdr_wdcnt_o;
  logic [5:0]  hdr_dtype_o;
  logic [1:0]  hdr_chID_o;
  logic        hdr_SPtype_o;
  logic        hdr_rd_lbfr_en_o;
  logic        hdr_xfrdone_o;

  int checks   = 0;
  int failures = 0;

  csi2_hdr_buffer #(.FIFO_DEPTH(4), .LBFR_BYTES(4), .CH_ID(2'd2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .hdr_wr_i(hdr_wr_i), .hdr_wdcnt_i(hdr_wdcnt_i), .hdr_dtype_i(hdr_dtype_i),
    .hdr_SPtype_i(hdr_SPtype_i), .hdr_full_o(hdr_full_o), .hdr_ovf_o(hdr_ovf_o),
    .arb_gnt_i(arb_gnt_i), .c2d_rd_rdy_i(c2d_rd_rdy_i), .hdr_req_o(hdr_req_o),
    .hdr_wdcnt_o(hdr_wdcnt_o), .hdr_dtype_o(hdr_dtype_o), .hdr_chID_o(hdr_chID_o),
    .hdr_SPtype_o(hdr_SPtype_o), .hdr_rd_lbfr_en_o(hdr_rd_lbfr_en_o),
    .hdr_xfrdone_o(hdr_xfrdone_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one push during the current cycle; it is sampled on the next edge.
  task automatic push(input logic sp, input logic [5:0] dt, input logic [15:0] wc);
    hdr_wr_i = 1'b1; hdr_SPtype_i = sp; hdr_dtype_i = dt; hdr_wdcnt_i = wc;
    tick();
    hdr_wr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; hdr_wr_i = 1'b0; hdr_wdcnt_i = '0; hdr_dtype_i = '0;
    hdr_SPtype_i = 1'b0; arb_gnt_i = 1'b0; c2d_rd_rdy_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({hdr_req_o, hdr_rd_lbfr_en_o, hdr_xfrdone_o, hdr_full_o, hdr_ovf_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req/en/done/full/ovf=%b required 00000",
               {hdr_req_o, hdr_rd_lbfr_en_o, hdr_xfrdone_o, hdr_full_o, hdr_ovf_o});
    end
    checks++;
    if ({hdr_wdcnt_o, hdr_dtype_o, hdr_SPtype_o} !== 23'h0) begin
      failures++;
      $display("FAIL reset_fields: got %h required 0", {hdr_wdcnt_o, hdr_dtype_o, hdr_SPtype_o});
    end
    checks++;
    if (hdr_chID_o !== 2'd2) begin
      failures++;
      $display("FAIL chid: got %0d required 2", hdr_chID_o);
    end
  endtask

  task automatic test_short();
    int strobes = 0;
    int dones   = 0;
    #1;
    push(1'b1, 6'h00, 16'h0001);
    // cycle T+1: FIFO non-empty, no request yet
    checks++;
    if (hdr_req_o !== 1'b0) begin
      failures++; $display("FAIL short_req_early: got %b required 0", hdr_req_o);
    end
    tick();
    checks++;
    if (hdr_req_o !== 1'b1) begin
      failures++; $display("FAIL short_req: got %b required 1", hdr_req_o);
    end
    checks++;
    if ({hdr_SPtype_o, hdr_dtype_o, hdr_wdcnt_o} !== {1'b1, 6'h00, 16'h0001}) begin
      failures++;
      $display("FAIL short_fields: got sp=%b dt=%h wc=%h required 1/00/0001",
               hdr_SPtype_o, hdr_dtype_o, hdr_wdcnt_o);
    end
    arb_gnt_i = 1'b1;
    c2d_rd_rdy_i = 1'b1;
    tick();
    checks++;
    if ({hdr_req_o, hdr_xfrdone_o} !== 2'b01) begin
      failures++;
      $display("FAIL short_done: got req=%b done=%b required req=0 done=1", hdr_req_o, hdr_xfrdone_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (hdr_rd_lbfr_en_o === 1'b1) strobes++;
      if (hdr_xfrdone_o === 1'b1) dones++;
      tick();
    end
    arb_gnt_i = 1'b0; c2d_rd_rdy_i = 1'b0;
    checks++;
    if (strobes != 0 || dones != 1) begin
      failures++;
      $display("FAIL short_counts: got strobes=%0d dones=%0d required 0/1", strobes, dones);
    end
    checks++;
    if ({hdr_req_o, hdr_full_o} !== 2'b00) begin
      failures++; $display("FAIL short_empty: got req=%b full=%b required 0/0", hdr_req_o, hdr_full_o);
    end
  endtask

  task automatic test_long();
    logic [3:0] pat = 4'b1101; // ready sequence 1,0,1,1 (bit 0 first)
    int strobes = 0;
    push(1'b0, 6'h2B, 16'd10);
    tick();
    checks++;
    if ({hdr_req_o, hdr_SPtype_o, hdr_dtype_o, hdr_wdcnt_o} !== {1'b1, 1'b0, 6'h2B, 16'd10}) begin
      failures++;
      $display("FAIL long_req: got req=%b sp=%b dt=%h wc=%0d required 1/0/2b/10",
               hdr_req_o, hdr_SPtype_o, hdr_dtype_o, hdr_wdcnt_o);
    end
    arb_gnt_i = 1'b1;
    tick();
    arb_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c2d_rd_rdy_i = pat[i];
      #1;
      checks++;
      if (hdr_rd_lbfr_en_o !== pat[i] || hdr_xfrdone_o !== 1'b0) begin
        failures++;
        $display("FAIL long_strobe%0d: got en=%b done=%b required en=%b done=0",
                 i, hdr_rd_lbfr_en_o, hdr_xfrdone_o, pat[i]);
      end
      if (hdr_rd_lbfr_en_o === 1'b1) strobes++;
      tick();
    end
    c2d_rd_rdy_i = 1'b1;
    #1;
    checks++;
    if ({hdr_xfrdone_o, hdr_rd_lbfr_en_o} !== 2'b10 || strobes != 3) begin
      failures++;
      $display("FAIL long_done: got done=%b en=%b strobes=%0d required 1/0/3",
               hdr_xfrdone_o, hdr_rd_lbfr_en_o, strobes);
    end
    c2d_rd_rdy_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_zero_long();
    push(1'b0, 6'h2A, 16'd0);
    tick();
    arb_gnt_i = 1'b1; c2d_rd_rdy_i = 1'b1;
    tick();
    arb_gnt_i = 1'b0;
    checks++;
    if ({hdr_req_o, hdr_xfrdone_o, hdr_rd_lbfr_en_o} !== 3'b010) begin
      failures++;
      $display("FAIL zero_done: got req/done/en=%b required 010",
               {hdr_req_o, hdr_xfrdone_o, hdr_rd_lbfr_en_o});
    end
    tick();
    checks++;
    if ({hdr_xfrdone_o, hdr_rd_lbfr_en_o} !== 2'b00) begin
      failures++;
      $display("FAIL zero_after: got done/en=%b required 00", {hdr_xfrdone_o, hdr_rd_lbfr_en_o});
    end
    c2d_rd_rdy_i = 1'b0;
    tick();
  endtask

  task automatic test_max();
    int strobes = 0;
    int dones   = 0;
    push(1'b0, 6'h2C, 16'hFFFF);
    tick();
    arb_gnt_i = 1'b1;
    tick();
    arb_gnt_i = 1'b0; c2d_rd_rdy_i = 1'b1;
    for (int i = 0; i < 17000 && dones == 0; i++) begin
      #1;
      if (hdr_rd_lbfr_en_o === 1'b1) strobes++;
      if (hdr_xfrdone_o === 1'b1) dones++;
      tick();
    end
    c2d_rd_rdy_i = 1'b0;
    checks++;
    if (strobes != 16384 || dones != 1) begin
      failures++;
      $display("FAIL max_wdcnt: got strobes=%0d dones=%0d required 16384/1", strobes, dones);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [15:0] seen [$];
    for (int i = 1; i <= 4; i++) push(1'b1, 6'(i), 16'(i * 16'h11));
    checks++;
    if ({hdr_full_o, hdr_ovf_o} !== 2'b10) begin
      failures++; $display("FAIL ovf_full4: got full/ovf=%b required 10", {hdr_full_o, hdr_ovf_o});
    end
    push(1'b1, 6'h05, 16'h0055);
    checks++;
    if ({hdr_full_o, hdr_ovf_o} !== 2'b11) begin
      failures++; $display("FAIL ovf_push5: got full/ovf=%b required 11", {hdr_full_o, hdr_ovf_o});
    end
    arb_gnt_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (hdr_xfrdone_o === 1'b1) seen.push_back(hdr_wdcnt_o);
      tick();
    end
    arb_gnt_i = 1'b0;
    checks++;
    if (seen.size() != 4) begin
      failures++; $display("FAIL ovf_dones: got %0d required 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 16'((i + 1) * 16'h11)) begin
          failures++;
          $display("FAIL ovf_order%0d: got %h required %h", i, seen[i], 16'((i + 1) * 16'h11));
        end
      end
    end
    checks++;
    if ({hdr_full_o, hdr_ovf_o} !== 2'b01) begin
      failures++; $display("FAIL ovf_sticky: got full/ovf=%b required 01", {hdr_full_o, hdr_ovf_o});
    end
  endtask

  task automatic test_midreset();
    int strobes = 0;
    int dones   = 0;
    push(1'b0, 6'h2B, 16'd20);
    tick();
    arb_gnt_i = 1'b1;
    tick();
    arb_gnt_i = 1'b0; c2d_rd_rdy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (hdr_rd_lbfr_en_o === 1'b1) strobes++;
      tick();
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (hdr_rd_lbfr_en_o !== 1'b0 || strobes != 2) begin
      failures++;
      $display("FAIL midrst_en: got en=%b strobes=%0d required 0/2", hdr_rd_lbfr_en_o, strobes);
    end
    tick();
    rst_i = 1'b0; c2d_rd_rdy_i = 1'b0;
    checks++;
    if ({hdr_req_o, hdr_rd_lbfr_en_o, hdr_xfrdone_o, hdr_full_o, hdr_ovf_o,
         hdr_wdcnt_o, hdr_dtype_o, hdr_SPtype_o} !== 28'h0) begin
      failures++;
      $display("FAIL midrst_outs: got req=%b en=%b done=%b full=%b ovf=%b wc=%h dt=%h sp=%b required all 0",
               hdr_req_o, hdr_rd_lbfr_en_o, hdr_xfrdone_o, hdr_full_o, hdr_ovf_o,
               hdr_wdcnt_o, hdr_dtype_o, hdr_SPtype_o);
    end
    arb_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (hdr_xfrdone_o === 1'b1 || hdr_req_o === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL midrst_quiet: got %0d req/done cycles required 0", dones);
    end
    push(1'b1, 6'h01, 16'h00AA);
    for (int i = 0; i < 10; i++) begin
      if (hdr_xfrdone_o === 1'b1 && hdr_wdcnt_o === 16'h00AA) dones++;
      tick();
    end
    arb_gnt_i = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++; $display("FAIL midrst_recover: got %0d dones required 1", dones);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_zero_long();
    test_overflow();
    test_max();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
